// File: rtl/sample_buffer.sv
// sample_buffer: DEPTH x WIDTH sample store read back newest-first (MODE=0) or oldest-first (MODE=1)
// Ports: clk, rst (sync, active-high); wr_en/wr_data push a sample; rd_en pops one sample;
// flush discards all entries; clr_err clears the sticky flags; rd_data/rd_valid hold the last
// popped sample and pulse when it is updated; level/full/empty report occupancy;
// overflow/underflow are sticky flags for a dropped write/read.
module sample_buffer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16,
    parameter int MODE  = 0,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam bit fifo_mode = MODE != 0;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp, rd_idx;
    logic push, pop, bypass, ovf_set, udf_set;
    // In LIFO mode wp doubles as the stack pointer; a simultaneous read and write
    // hands wr_data straight to rd_data and leaves the stack untouched.
    always_comb begin
        push    = wr_en && (rd_en ? fifo_mode : !full);
        pop     = rd_en && !empty && (!wr_en || fifo_mode);
        bypass  = wr_en && rd_en && !fifo_mode;
        ovf_set = wr_en && !rd_en && full;
        udf_set = rd_en && empty && !bypass;
        rd_idx  = fifo_mode ? rp : wp - AW'(1);
    end
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            level     <= level + LW'(push) - LW'(pop);
            wp        <= fifo_mode ? wp + AW'(push) : wp + AW'(push) - AW'(pop);
            rp        <= rp + AW'(pop && fifo_mode);
            rd_valid  <= pop || bypass;
            if (pop || bypass) rd_data <= bypass ? wr_data : mem[rd_idx];
            overflow  <= ovf_set || (overflow && !clr_err);
            underflow <= udf_set || (underflow && !clr_err);
        end
    end
    // A FIFO push while full lands on the slot being popped; the pop reads the old value.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem[wp] <= wr_data;
    end
endmodule

// File: tb/tb_sample_buffer.sv
// tb_sample_buffer: drives a LIFO and a FIFO instance with identical stimulus and checks both against queue models
module tb_sample_buffer;
    localparam int W = 12;
    localparam int D = 4;
    localparam int LW = $clog2(D + 1);
    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic rd_en = 1'b0;
    logic flush = 1'b0;
    logic clr_err = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 tb_clk = ~tb_clk;
    function automatic void chk(int lane, string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL lane%0d %s: got %0d expected %0d", lane, nm, act, expv);
    endfunction
    for (genvar g = 0; g < 2; g++) begin : lane
        logic [W-1:0] rd_data;
        logic rd_valid, full, empty, overflow, underflow;
        logic [LW-1:0] level;
        sample_buffer #(.WIDTH(W), .DEPTH(D), .MODE(g)) dut (
            .clk(tb_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
            .flush(flush), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
            .level(level), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
        );
        logic [W-1:0] st[$];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] m_rd = '0;
        bit m_v = 0, m_ovf = 0, m_udf = 0, ov, ud;
        // Reference: a plain queue; LIFO pops the back, FIFO pops the front.
        always @(posedge tb_clk) begin
            m_v = 0;
            ov = 0;
            ud = 0;
            if (rst) begin
                st.delete();
                m_rd = '0;
                m_ovf = 0;
                m_udf = 0;
            end else if (flush) begin
                st.delete();
            end else begin
                if (wr_en && rd_en && g == 0) begin
                    m_rd = wr_data;
                    m_v = 1;
                end else if (wr_en && rd_en) begin
                    if (st.size() == 0) ud = 1;
                    else begin
                        m_rd = st.pop_front();
                        m_v = 1;
                    end
                    st.push_back(wr_data);
                end else if (wr_en) begin
                    if (st.size() == D) ov = 1;
                    else st.push_back(wr_data);
                end else if (rd_en) begin
                    if (st.size() == 0) ud = 1;
                    else begin
                        m_rd = (g == 1) ? st.pop_front() : st.pop_back();
                        m_v = 1;
                    end
                end
                m_ovf = ov || (m_ovf && !clr_err);
                m_udf = ud || (m_udf && !clr_err);
            end
            if (m_v) exp_q.push_back(m_rd);
        end
        always @(negedge tb_clk) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) chk(g, "unexpected rd_valid", 1, 0);
                else chk(g, "popped sample", 32'(rd_data), 32'(exp_q.pop_front()));
            end
            chk(g, "rd_valid", 32'(rd_valid), 32'(m_v));
            chk(g, "rd_data", 32'(rd_data), 32'(m_rd));
            chk(g, "level", 32'(level), st.size());
            chk(g, "full", 32'(full), 32'(st.size() == D));
            chk(g, "empty", 32'(empty), 32'(st.size() == 0));
            chk(g, "overflow", 32'(overflow), 32'(m_ovf));
            chk(g, "underflow", 32'(underflow), 32'(m_udf));
        end
    end
    task automatic cyc(input bit w, input int wd, input bit r, input bit f = 0, input bit c = 0, input bit rs = 0);
        @(negedge tb_clk);
        #1;
        wr_en = w;
        wr_data = W'(wd);
        rd_en = r;
        flush = f;
        clr_err = c;
        rst = rs;
    endtask
    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 200, 0);
        cyc(1, 100, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(1, i, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 6, 0);
        cyc(1, 7, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 55, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, i, 0);
        cyc(1, 9, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        for (int i = 1; i <= 3; i++) cyc(1, 10 + i, 0);
        cyc(1, 99, 0, 1);
        cyc(1, 21, 0);
        cyc(1, 22, 0);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) < 50, $urandom_range(0, 4095), $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, $urandom_range(0, 199) < 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(negedge tb_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
